// File: rtl/framing_pkg.sv
// Shared framing constants and state encoding, common to the framer and deframer.
package framing_pkg;

    localparam logic [15:0] FRAME_SFD      = 16'hF398;
    localparam logic [63:0] FRAME_PREAMBLE = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam int          FRAME_DATA_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DISCARD = 2'd3
    } frame_state_e;

endpackage

// File: rtl/deframer_fifo.sv
// First-word-fall-through byte FIFO; the head is visible combinationally whenever not empty.
module deframer_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q;
    logic [ADDR_W:0]   rd_ptr_q;
    logic              do_push;
    logic              do_pop;

    // Extra wrap bit distinguishes full from empty when the index bits coincide.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/deframer.sv
// Serial deframer: hunts for the SFD after a minimum preamble, then packs LSB-first payload bytes into a FIFO.
module deframer
    import framing_pkg::*;
#(
    parameter logic [15:0] SFD          = FRAME_SFD,
    parameter int          PREAMBLE_MIN = 32,
    parameter int          SYNC_MAX     = 80,
    parameter int          DATA_W       = FRAME_DATA_W,
    parameter int          ADDR_W       = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_in,
    input  logic              data_in_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    input  logic              data_out_ready,
    output logic              frame_sync,
    output logic              frame_end,
    output logic              frame_err,
    output logic              overflow,
    output logic              frame_busy
);

    localparam int CNT_W = $clog2(SYNC_MAX + 1);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] SYNC_LIMIT = CNT_W'(SYNC_MAX);
    localparam logic [CNT_W-1:0] MATCH_MIN  = CNT_W'(PREAMBLE_MIN + 16);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_W - 1);

    frame_state_e      state_q;
    logic [15:0]       shift_q;
    logic [15:0]       shift_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] byte_q;
    logic [DATA_W-1:0] byte_d;
    logic              frame_sync_q;
    logic              frame_end_q;
    logic              frame_err_q;
    logic              overflow_q;

    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;

    assign shift_d = {data_in, shift_q[15:1]};
    assign cnt_d   = (cnt_q == SYNC_LIMIT) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        byte_d        = byte_q;
        byte_d[idx_q] = data_in;
    end

    // The completing bit goes straight into the FIFO so the byte is visible right after its last edge.
    assign push = (state_q == ST_PAYLOAD) && data_in_valid && (idx_q == LAST_IDX);
    assign pop  = data_out_valid && data_out_ready;

    deframer_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (byte_d),
        .pop       (pop),
        .head      (data_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            byte_q       <= '0;
            frame_sync_q <= 1'b0;
            frame_end_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            frame_sync_q <= 1'b0;
            frame_end_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= push && fifo_full && !pop;
            case (state_q)
                ST_IDLE: begin
                    if (data_in_valid) begin
                        state_q <= ST_SYNC;
                        shift_q <= {data_in, 15'b0};
                        cnt_q   <= CNT_W'(1);
                    end
                end
                ST_SYNC: begin
                    if (!data_in_valid) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_d;
                        // A match on the final allowed bit still counts as a sync.
                        if ((shift_d == SFD) && (cnt_d >= MATCH_MIN)) begin
                            frame_sync_q <= 1'b1;
                            state_q      <= ST_PAYLOAD;
                            idx_q        <= '0;
                        end else if (cnt_d == SYNC_LIMIT) begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_DISCARD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (!data_in_valid) begin
                        if (idx_q == '0) begin
                            frame_end_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end else begin
                        byte_q <= byte_d;
                        idx_q  <= idx_q + 1'b1;
                    end
                end
                ST_DISCARD: begin
                    if (!data_in_valid) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_out_valid = !fifo_empty;
    assign frame_sync     = frame_sync_q;
    assign frame_end      = frame_end_q;
    assign frame_err      = frame_err_q;
    assign overflow       = overflow_q;
    assign frame_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_deframer.sv
// Directed bench for the deframer: clean frame, short preamble, overflow, truncation, reset and full-FIFO cases.
module tb_deframer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       data_in;
    logic       data_in_valid;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       frame_sync;
    logic       frame_end;
    logic       frame_err;
    logic       overflow;
    logic       frame_busy;

    int checks   = 0;
    int failures = 0;

    int sync_cnt = 0;
    int end_cnt  = 0;
    int err_cnt  = 0;
    int ovf_cnt  = 0;
    logic [7:0] popq [$];

    localparam logic [63:0] PRE = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] SFDV = 64'h0000_0000_0000_F398;

    always #5 clk = ~clk;

    deframer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .frame_sync     (frame_sync),
        .frame_end      (frame_end),
        .frame_err      (frame_err),
        .overflow       (overflow),
        .frame_busy     (frame_busy)
    );

    // Pulse counters and accepted-byte log, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_sync) sync_cnt++;
            if (frame_end)  end_cnt++;
            if (frame_err)  err_cnt++;
            if (overflow)   ovf_cnt++;
            if (data_out_valid && data_out_ready) popq.push_back(data_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        data_in       = b;
        data_in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[i]);
    endtask

    task automatic idle(input int n);
        data_in       = 1'b0;
        data_in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_frame(input int pre);
        send_bits(PRE, pre);
        send_bits(SFDV, 16);
    endtask

    int s0, e0, r0, o0, p0;
    task automatic mark();
        s0 = sync_cnt; e0 = end_cnt; r0 = err_cnt; o0 = ovf_cnt; p0 = popq.size();
    endtask

    task automatic drain(input int n);
        data_out_ready = 1'b1;
        idle(n);
        data_out_ready = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        data_in        = 1'b0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b0;
        #1;
        check("rst_valid", data_out_valid, 0);
        check("rst_data", data_out, 0);
        check("rst_busy", frame_busy, 0);
        check("rst_pulses", {frame_sync, frame_end, frame_err, overflow}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Clean frame 0x5A, 0xC3
        mark();
        data_out_ready = 1'b1;
        send_bits(PRE, 64);
        send_bits(SFDV, 15);
        check("f1_no_early_sync", sync_cnt - s0, 0);
        check("f1_busy", frame_busy, 1);
        send_bit(1'b1);
        check("f1_sync_pulse", frame_sync, 1);
        send_bits(64'h5A, 8);
        check("f1_latency_valid", data_out_valid, 1);
        check("f1_latency_data", data_out, 8'h5A);
        send_bits(64'hC3, 8);
        idle(3);
        check("f1_sync_cnt", sync_cnt - s0, 1);
        check("f1_end_cnt", end_cnt - e0, 1);
        check("f1_err_cnt", err_cnt - r0, 0);
        check("f1_pop_cnt", popq.size() - p0, 2);
        check("f1_byte0", popq[p0], 8'h5A);
        check("f1_byte1", popq[p0+1], 8'hC3);
        check("f1_idle", frame_busy, 0);

        // Short preamble: SFD too early, error when the count hits 80
        mark();
        start_frame(16);
        send_bits(64'h0, 47);
        check("sp_no_err_79", err_cnt - r0, 0);
        send_bit(1'b0);
        check("sp_err_pulse", frame_err, 1);
        send_bits(PRE, 12);
        check("sp_discard_busy", frame_busy, 1);
        idle(3);
        check("sp_err_cnt", err_cnt - r0, 1);
        check("sp_no_sync", sync_cnt - s0, 0);
        check("sp_no_end", end_cnt - e0, 0);
        check("sp_no_output", data_out_valid, 0);

        // Overflow: 10 bytes with the consumer stalled
        mark();
        data_out_ready = 1'b0;
        start_frame(64);
        for (int b = 1; b <= 10; b++) send_bits(64'(b), 8);
        idle(3);
        check("ov_pulses", ovf_cnt - o0, 2);
        check("ov_end", end_cnt - e0, 1);
        check("ov_head", data_out, 8'h01);
        drain(10);
        check("ov_drain_cnt", popq.size() - p0, 8);
        for (int k = 0; k < 8; k++) check("ov_drain_byte", popq[p0+k], 32'(k + 1));
        check("ov_empty", data_out_valid, 0);

        // Truncation 3 bits into the second byte
        mark();
        data_out_ready = 1'b1;
        start_frame(64);
        send_bits(64'h77, 8);
        send_bits(64'h05, 3);
        idle(1);
        check("tr_err_pulse", frame_err, 1);
        idle(3);
        check("tr_err_cnt", err_cnt - r0, 1);
        check("tr_no_end", end_cnt - e0, 0);
        check("tr_pop_cnt", popq.size() - p0, 1);
        check("tr_byte", popq[p0], 8'h77);
        check("tr_empty", data_out_valid, 0);

        // Asynchronous reset mid-payload
        data_out_ready = 1'b0;
        start_frame(64);
        send_bits(64'h11, 8);
        send_bits(64'h0F, 4);
        check("rs_pre_valid", data_out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_valid", data_out_valid, 0);
        check("rs_data", data_out, 0);
        check("rs_busy", frame_busy, 0);
        check("rs_pulses", {frame_sync, frame_end, frame_err, overflow}, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(2);
        mark();
        data_out_ready = 1'b1;
        start_frame(64);
        send_bits(64'h3C, 8);
        send_bits(64'h99, 8);
        idle(3);
        check("rs_sync", sync_cnt - s0, 1);
        check("rs_end", end_cnt - e0, 1);
        check("rs_pop_cnt", popq.size() - p0, 2);
        check("rs_byte0", popq[p0], 8'h3C);
        check("rs_byte1", popq[p0+1], 8'h99);

        // Full FIFO with a pop and a push on the same edge
        mark();
        data_out_ready = 1'b0;
        start_frame(64);
        for (int b = 0; b < 8; b++) send_bits(64'(8'h20 + b), 8);
        send_bits(64'h28, 7);
        check("ff_full_head", data_out, 8'h20);
        data_out_ready = 1'b1;
        send_bit(1'b0);
        data_out_ready = 1'b0;
        check("ff_no_ovf_pulse", overflow, 0);
        check("ff_head_next", data_out, 8'h21);
        idle(3);
        check("ff_ovf_cnt", ovf_cnt - o0, 0);
        check("ff_end", end_cnt - e0, 1);
        drain(12);
        check("ff_pop_cnt", popq.size() - p0, 9);
        for (int k = 0; k < 9; k++) check("ff_order", popq[p0+k], 32'(8'h20 + k));
        check("ff_empty", data_out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
